ycbcr2rgb_matrix: RTL and testbench

//  Inverse colour-space converter: 8-bit full-range BT.601 YCbCr in, 8-bit RGB out.

---
 rtl/ycbcr2rgb_matrix_pkg.sv | 18 +
 rtl/ycc_round_clamp.sv | 26 ++
 rtl/ycbcr2rgb_matrix.sv | 161 ++++++++++++++++
 tb/tb_ycbcr2rgb_matrix.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ycbcr2rgb_matrix_pkg.sv
// Shared colour-matrix constants for the YCbCr<->RGB pair.
// The forward and inverse blocks both import these values so that they use the same coefficients.
package ycbcr2rgb_matrix_pkg;

    // Fixed-point coefficient format: unsigned magnitude below 2^11, plus a sign bit.
    localparam int COEF_FRAC  = 10;
    localparam int COEF_W     = 12;

    // BT.601 full-range inverse coefficients, round(k * 2^COEF_FRAC).
    localparam int COEF_K_RCR = 1436;  // 1.402    Cr -> R
    localparam int COEF_K_GCB = 352;   // 0.344136 Cb -> G
    localparam int COEF_K_GCR = 731;   // 0.714136 Cr -> G
    localparam int COEF_K_BCB = 1815;  // 1.772    Cb -> B

    // Chroma is stored offset-binary around this value.
    localparam int CHROMA_OFS = 128;

endpackage

// File: rtl/ycc_round_clamp.sv
// Signed fixed-point sum -> round half up -> saturate to an unsigned DW-bit component.
module ycc_round_clamp #(
    parameter int DW   = 8,
    parameter int SW   = 22,
    parameter int FRAC = 10
) (
    input  logic signed [SW-1:0] s,
    output logic        [DW-1:0] v
);

    logic signed [SW-1:0] biased;
    logic signed [SW-1:0] shifted;

    // Add half an LSB, drop the fraction, then clamp to [0, 2^DW-1].
    always_comb begin
        biased  = s + SW'(1 << (FRAC - 1));
        shifted = biased >>> FRAC;
        v       = shifted[DW-1:0];
        if (shifted[SW-1]) begin
            v = '0;
        end else if (shifted > $signed(SW'((1 << DW) - 1))) begin
            v = '1;
        end
    end

endmodule

// File: rtl/ycbcr2rgb_matrix.sv
// Inverse BT.601 full-range colour matrix: YCbCr -> RGB in three register stages.
// All stages freeze together whenever the output is stalled. Bubbles stay in the pipe.
module ycbcr2rgb_matrix
    import ycbcr2rgb_matrix_pkg::*;
#(
    parameter int DW    = 8,
    parameter int UW    = 2,
    parameter int FRAC  = COEF_FRAC,
    parameter int K_RCR = COEF_K_RCR,
    parameter int K_GCB = COEF_K_GCB,
    parameter int K_GCR = COEF_K_GCR,
    parameter int K_BCB = COEF_K_BCB
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] y,
    input  logic [DW-1:0] cb,
    input  logic [DW-1:0] cr,
    input  logic [UW-1:0] in_user,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] r,
    output logic [DW-1:0] g,
    output logic [DW-1:0] b,
    output logic [UW-1:0] out_user
);

    localparam int STAGES = 3;
    localparam int YSW    = DW + FRAC + 1;   // y << FRAC with a sign bit
    localparam int DSW    = DW + 1;          // offset-removed chroma
    localparam int PW     = DSW + COEF_W;    // coefficient * chroma
    localparam int SW     = PW + 1;          // luma plus up to two products

    localparam logic signed [COEF_W-1:0] KS_RCR = COEF_W'(K_RCR);
    localparam logic signed [COEF_W-1:0] KS_GCB = COEF_W'(K_GCB);
    localparam logic signed [COEF_W-1:0] KS_GCR = COEF_W'(K_GCR);
    localparam logic signed [COEF_W-1:0] KS_BCB = COEF_W'(K_BCB);

    logic                  stall;
    logic [STAGES:1]       vld_pipe_q, vld_pipe_d;

    // S1 registers
    logic signed [YSW-1:0] ys1_q, ys1_d;
    logic signed [DSW-1:0] dcb_q, dcb_d;
    logic signed [DSW-1:0] dcr_q, dcr_d;
    logic [UW-1:0]         user1_q, user1_d;

    // S2 registers
    logic signed [YSW-1:0] ys2_q, ys2_d;
    logic signed [PW-1:0]  pr_q, pr_d;
    logic signed [PW-1:0]  pgb_q, pgb_d;
    logic signed [PW-1:0]  pgr_q, pgr_d;
    logic signed [PW-1:0]  pb_q, pb_d;
    logic [UW-1:0]         user2_q, user2_d;

    // S3 (output) registers
    logic [DW-1:0]         r_q, r_d;
    logic [DW-1:0]         g_q, g_d;
    logic [DW-1:0]         b_q, b_d;
    logic [UW-1:0]         out_user_q, out_user_d;

    logic signed [SW-1:0]  sum_r, sum_g, sum_b;
    logic [DW-1:0]         r_rc, g_rc, b_rc;

    // The whole pipe advances unless a valid output is being refused.
    assign stall    = vld_pipe_q[STAGES] & ~out_ready;
    assign in_ready = ~stall;

    // Stage-3 accumulation. The widths leave headroom so that no sum can overflow.
    always_comb begin
        sum_r = SW'(ys2_q) + SW'(pr_q);
        sum_g = SW'(ys2_q) - SW'(pgb_q) - SW'(pgr_q);
        sum_b = SW'(ys2_q) + SW'(pb_q);
    end

    ycc_round_clamp #(.DW(DW), .SW(SW), .FRAC(FRAC)) u_rc_r (.s(sum_r), .v(r_rc));
    ycc_round_clamp #(.DW(DW), .SW(SW), .FRAC(FRAC)) u_rc_g (.s(sum_g), .v(g_rc));
    ycc_round_clamp #(.DW(DW), .SW(SW), .FRAC(FRAC)) u_rc_b (.s(sum_b), .v(b_rc));

    // Next-state for every stage. Stages hold on stall. Data is clocked even when its valid is low.
    always_comb begin
        vld_pipe_d = vld_pipe_q;
        ys1_d      = ys1_q;
        dcb_d      = dcb_q;
        dcr_d      = dcr_q;
        user1_d    = user1_q;
        ys2_d      = ys2_q;
        pr_d       = pr_q;
        pgb_d      = pgb_q;
        pgr_d      = pgr_q;
        pb_d       = pb_q;
        user2_d    = user2_q;
        r_d        = r_q;
        g_d        = g_q;
        b_d        = b_q;
        out_user_d = out_user_q;
        if (!stall) begin
            vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};
            ys1_d      = $signed({1'b0, y, {FRAC{1'b0}}});
            dcb_d      = $signed({1'b0, cb}) - DSW'(CHROMA_OFS);
            dcr_d      = $signed({1'b0, cr}) - DSW'(CHROMA_OFS);
            user1_d    = in_user;
            ys2_d      = ys1_q;
            pr_d       = PW'(KS_RCR) * PW'(dcr_q);
            pgb_d      = PW'(KS_GCB) * PW'(dcb_q);
            pgr_d      = PW'(KS_GCR) * PW'(dcr_q);
            pb_d       = PW'(KS_BCB) * PW'(dcb_q);
            user2_d    = user1_q;
            r_d        = r_rc;
            g_d        = g_rc;
            b_d        = b_rc;
            out_user_d = user2_q;
        end
    end

    // Pipeline registers. Reset discards every in-flight pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe_q <= '0;
            ys1_q      <= '0;
            dcb_q      <= '0;
            dcr_q      <= '0;
            user1_q    <= '0;
            ys2_q      <= '0;
            pr_q       <= '0;
            pgb_q      <= '0;
            pgr_q      <= '0;
            pb_q       <= '0;
            user2_q    <= '0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
            out_user_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            ys1_q      <= ys1_d;
            dcb_q      <= dcb_d;
            dcr_q      <= dcr_d;
            user1_q    <= user1_d;
            ys2_q      <= ys2_d;
            pr_q       <= pr_d;
            pgb_q      <= pgb_d;
            pgr_q      <= pgr_d;
            pb_q       <= pb_d;
            user2_q    <= user2_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            out_user_q <= out_user_d;
        end
    end

    assign out_valid = vld_pipe_q[STAGES];
    assign r         = r_q;
    assign g         = g_q;
    assign b         = b_q;
    assign out_user  = out_user_q;

endmodule

// File: tb/tb_ycbcr2rgb_matrix.sv
// Directed and scoreboarded bench for ycbcr2rgb_matrix.
module tb_ycbcr2rgb_matrix;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] y = '0, cb = '0, cr = '0;
    logic [1:0] in_user = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] r, g, b;
    logic [1:0] out_user;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [1:0] u;
    } pix_t;

    always #5 clk = ~clk;

    ycbcr2rgb_matrix dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .cb(cb), .cr(cr), .in_user(in_user),
        .out_valid(out_valid), .out_ready(out_ready),
        .r(r), .g(g), .b(b), .out_user(out_user)
    );

    // Reference arithmetic for the random scoreboard, written directly from the BT.601 inverse matrix.
    function automatic logic [7:0] clamp_round(int s);
        int v;
        v = (s + 512) >>> 10;
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    function automatic pix_t model(int yy, int cbb, int crr, logic [1:0] u);
        pix_t p;
        int dcb, dcr;
        dcb = cbb - 128;
        dcr = crr - 128;
        p.r = clamp_round(yy * 1024 + 1436 * dcr);
        p.g = clamp_round(yy * 1024 - 352 * dcb - 731 * dcr);
        p.b = clamp_round(yy * 1024 + 1815 * dcb);
        p.u = u;
        return p;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        #3;
        vectors++;
        if ({out_valid, r, g, b, out_user} !== 27'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b rgb=%h u=%h rdy=%b, want v=0 rgb=000000 u=0 rdy=1",
                     out_valid, {r, g, b}, out_user, in_ready);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_release_spurious: cycle %0d got out_valid=%b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_grey();
        int   ty[3] = '{128, 255, 0};
        pix_t ex[3] = '{'{8'd128, 8'd128, 8'd128, 2'd1},
                        '{8'd255, 8'd255, 8'd255, 2'd2},
                        '{8'd0,   8'd0,   8'd0,   2'd3}};
        for (int i = 0; i < 3; i++) begin
            y = 8'(ty[i]); cb = 8'd128; cr = 8'd128; in_user = 2'(i + 1); in_valid = 1'b1;
            @(posedge clk); #1 in_valid = 1'b0;
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL grey_early_valid: pix %0d edge %0d got out_valid=%b want 0", i, k + 1, out_valid);
                end
                @(posedge clk); #1;
            end
            vectors++;
            if (out_valid !== 1'b1 || {r, g, b, out_user} !== ex[i]) begin
                miscompares++;
                $display("FAIL grey_pixel: pix %0d got v=%b rgb=(%0d,%0d,%0d) u=%0d want v=1 rgb=(%0d,%0d,%0d) u=%0d",
                         i, out_valid, r, g, b, out_user, ex[i].r, ex[i].g, ex[i].b, ex[i].u);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        int   ty[3] = '{76, 0, 255};
        int   tb[3] = '{85, 128, 255};
        int   tr[3] = '{255, 255, 128};
        pix_t ex[3] = '{'{8'd254, 8'd0,   8'd0,   2'd0},
                        '{8'd178, 8'd0,   8'd0,   2'd1},
                        '{8'd255, 8'd211, 8'd255, 2'd2}};
        for (int i = 0; i < 3; i++) begin
            y = 8'(ty[i]); cb = 8'(tb[i]); cr = 8'(tr[i]); in_user = 2'(i); in_valid = 1'b1;
            @(posedge clk); #1 in_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            vectors++;
            if (out_valid !== 1'b1 || {r, g, b, out_user} !== ex[i]) begin
                miscompares++;
                $display("FAIL sat_round: pix %0d got v=%b rgb=(%0d,%0d,%0d) u=%0d want v=1 rgb=(%0d,%0d,%0d) u=%0d",
                         i, out_valid, r, g, b, out_user, ex[i].r, ex[i].g, ex[i].b, ex[i].u);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] e8;
        for (int c = 0; c < 19; c++) begin
            if (c < 16) begin
                y = 8'(c * 17); cb = 8'd128; cr = 8'd128; in_user = 2'(c); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (c >= 2 && c < 18) begin
                e8 = 8'((c - 2) * 17);
                vectors++;
                if (out_valid !== 1'b1 || r !== e8 || g !== e8 || b !== e8 || out_user !== 2'(c - 2)) begin
                    miscompares++;
                    $display("FAIL stream: idx %0d got v=%b rgb=(%0d,%0d,%0d) u=%0d want v=1 rgb=(%0d,%0d,%0d) u=%0d",
                             c - 2, out_valid, r, g, b, out_user, e8, e8, e8, 2'(c - 2));
                end
            end else if (c == 18) begin
                vectors++;
                if (out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stream_tail: got out_valid=%b want 0", out_valid);
                end
            end
        end
    endtask

    task automatic test_fill_and_drain();
        int ey[4] = '{40, 80, 120, 160};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            y = 8'(ey[i]); cb = 8'd128; cr = 8'd128; in_user = 2'(i); in_valid = 1'b1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL fill_no_stall: pix %0d got in_ready=%b want 1", i, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || r !== 8'd40 || out_user !== 2'd0) begin
                miscompares++;
                $display("FAIL stall_hold: cycle %0d got v=%b rdy=%b r=%0d u=%0d want v=1 rdy=0 r=40 u=0",
                         k, out_valid, in_ready, r, out_user);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        y = 8'd160; cb = 8'd128; cr = 8'd128; in_user = 2'd3; in_valid = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_ready: got in_ready=%b want 1", in_ready);
        end
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1 in_valid = 1'b0;
            vectors++;
            if (out_valid !== 1'b1 || r !== 8'(ey[k]) || b !== 8'(ey[k]) || out_user !== 2'(k)) begin
                miscompares++;
                $display("FAIL drain_order: idx %0d got v=%b r=%0d b=%0d u=%0d want v=1 r=%0d b=%0d u=%0d",
                         k, out_valid, r, b, out_user, ey[k], ey[k], k);
            end
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_tail: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        pix_t q[$];
        pix_t exp_p, held;
        bit   prev_stall = 1'b0;
        int   sent = 0, recv = 0, cyc = 0;
        in_valid = 1'b0;
        while (recv < 200 && cyc < 4000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 200 && !in_valid) begin
                y = 8'($urandom_range(0, 255));
                cb = 8'($urandom_range(0, 255));
                cr = 8'($urandom_range(0, 255));
                in_user = 2'($urandom_range(0, 3));
                in_valid = 1'b1;
            end
            #3;
            if (prev_stall) begin
                vectors++;
                if (out_valid !== 1'b1 || {r, g, b, out_user} !== held) begin
                    miscompares++;
                    $display("FAIL bp_stable: cycle %0d got v=%b data=%h want v=1 data=%h",
                             cyc, out_valid, {r, g, b, out_user}, held);
                end
            end
            vectors++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                miscompares++;
                $display("FAIL bp_in_ready: cycle %0d got %b want %b", cyc, in_ready, !(out_valid && !out_ready));
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL bp_extra: cycle %0d got output %h want none", cyc, {r, g, b, out_user});
                end else begin
                    exp_p = q.pop_front();
                    if ({r, g, b, out_user} !== exp_p) begin
                        miscompares++;
                        $display("FAIL bp_data: out %0d got %h want %h", recv, {r, g, b, out_user}, exp_p);
                    end
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(int'(y), int'(cb), int'(cr), in_user));
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            held = {r, g, b, out_user};
            @(posedge clk); #1;
            if (in_valid && sent > 0 && q.size() > 0 && prev_stall == 1'b0) begin
                // pixel consumed on that edge if it was accepted; clear to fetch a fresh one
            end
            if (in_valid && (sent != 0)) in_valid = (sent < 200) ? 1'b0 : 1'b0;
            cyc++;
        end
        vectors++;
        if (recv < 200 || q.size() != 0) begin
            miscompares++;
            $display("FAIL bp_complete: got %0d outputs, %0d left queued, want 200 and 0", recv, q.size());
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drained: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 2; i++) begin
            y = 8'd99; cb = 8'd30; cr = 8'd200; in_user = 2'd3; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        vectors++;
        if ({out_valid, r, g, b, out_user} !== 27'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_state: got v=%b rgb=%h u=%h rdy=%b want all 0, rdy=1",
                     out_valid, {r, g, b}, out_user, in_ready);
        end
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset_ghost: cycle %0d got out_valid=%b want 0", k, out_valid);
            end
        end
        y = 8'd200; cb = 8'd128; cr = 8'd128; in_user = 2'd2; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_early: got out_valid=%b want 0", out_valid);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b1 || {r, g, b, out_user} !== {8'd200, 8'd200, 8'd200, 2'd2}) begin
            miscompares++;
            $display("FAIL midreset_first: got v=%b rgb=(%0d,%0d,%0d) u=%0d want v=1 rgb=(200,200,200) u=2",
                     out_valid, r, g, b, out_user);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_trip();
        // Forward-matrix outputs for RGB (0x88,0x55,0x33) and (0xF0,0xF0,0xF0).
        int   ty[2] = '{96, 240};
        int   tb[2] = '{102, 128};
        int   tr[2] = '{156, 128};
        pix_t orig[2] = '{'{8'h88, 8'h55, 8'h33, 2'd0}, '{8'hF0, 8'hF0, 8'hF0, 2'd1}};
        pix_t ex[2]   = '{'{8'd135, 8'd85, 8'd50, 2'd0}, '{8'd240, 8'd240, 8'd240, 2'd1}};
        int dr, dg, db;
        for (int i = 0; i < 2; i++) begin
            y = 8'(ty[i]); cb = 8'(tb[i]); cr = 8'(tr[i]); in_user = 2'(i); in_valid = 1'b1;
            @(posedge clk); #1 in_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            vectors++;
            if (out_valid !== 1'b1 || {r, g, b, out_user} !== ex[i]) begin
                miscompares++;
                $display("FAIL roundtrip_exact: pix %0d got v=%b rgb=(%0d,%0d,%0d) want v=1 rgb=(%0d,%0d,%0d)",
                         i, out_valid, r, g, b, ex[i].r, ex[i].g, ex[i].b);
            end
            dr = int'(r) - int'(orig[i].r);
            dg = int'(g) - int'(orig[i].g);
            db = int'(b) - int'(orig[i].b);
            vectors++;
            if (dr > 2 || dr < -2 || dg > 2 || dg < -2 || db > 2 || db < -2) begin
                miscompares++;
                $display("FAIL roundtrip_tol: pix %0d got rgb=(%0d,%0d,%0d) want within 2 of (%0d,%0d,%0d)",
                         i, r, g, b, orig[i].r, orig[i].g, orig[i].b);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_grey();
        test_saturation();
        test_back_to_back();
        test_fill_and_drain();
        test_backpressure();
        test_reset_midstream();
        test_round_trip();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
